// File: rtl/impl_serial_unit.sv
// impl_serial_unit: bit-serial implication engine.
// Accepts an operand pair (a, b), evaluates res[i] = ~a[i] | b[i] one bit per
// clock through a single implication cell, and presents the result word over
// an output valid/ready handshake.
// Optional feature macro: IMPL_VIOL_CNT_EN adds the viol_cnt output, a count of
// bit positions with a=1, b=0 (the positions where the implication is false).
module impl_serial_unit #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res
`ifdef IMPL_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0] viol_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             cell_bit;

    // The implication cell: fed by the LSBs of the operand shift registers.
    assign cell_bit = ~a_q[0] | b_q[0];

    // Handshake outputs are pure decodes of the registered state, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_res   = res_q;

    // Next-state and datapath updates for the accept / shift / hand-off sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (idx_q == CNT_W'(i)) begin
                        res_d[i] = cell_bit;
                    end
                end
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                // Index saturates on the last bit; it is only cleared by the next accept.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // No accept here: IDLE is re-entered on the handshake edge.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

`ifdef IMPL_VIOL_CNT_EN
    logic [CNT_W-1:0] viol_q, viol_d;

    // Violation counter: cleared on accept, bumped on each shifted a=1/b=0 pair.
    always_comb begin
        viol_d = viol_q;
        if (state_q == S_IDLE && in_valid) begin
            viol_d = '0;
        end else if (state_q == S_SHIFT && a_q[0] && !b_q[0]) begin
            viol_d = viol_q + CNT_W'(1);
        end
    end

    // Violation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_q <= '0;
        end else begin
            viol_q <= viol_d;
        end
    end

    assign viol_cnt = viol_q;
`endif

endmodule

// File: tb/tb_impl_serial_unit.sv
// tb_impl_serial_unit: directed self-checking bench for impl_serial_unit (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// The viol_cnt checks are active when IMPL_VIOL_CNT_EN is defined.
module tb_impl_serial_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
`ifdef IMPL_VIOL_CNT_EN
    logic [CNT_W-1:0] viol_cnt;
`endif

    int n_cmp;
    int n_err;

    impl_serial_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
`ifdef IMPL_VIOL_CNT_EN
        ,
        .viol_cnt  (viol_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an operand pair and let the accept edge happen; returns at the
    // falling edge right after the accept with in_valid dropped.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (bounded), checking latency, result and count.
    // Called at the falling edge right after the accept edge.
    task automatic wait_result(input string name, input logic [WIDTH-1:0] exp_res,
                               input int exp_viol);
        int edges;
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        // Accept edge plus WIDTH shift edges.
        check_eq({name, "_latency"}, 64'(edges), 64'(WIDTH + 1));
        check_eq({name, "_res"}, 64'(out_res), 64'(exp_res));
        check_eq({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
`ifdef IMPL_VIOL_CNT_EN
        check_eq({name, "_viol"}, 64'(viol_cnt), 64'(exp_viol));
`endif
        $display("txn %s: res=0x%0h exp=0x%0h exp_viol=%0d latency=%0d", name, out_res,
                 exp_res, exp_viol, edges);
    endtask

    // Complete the output handshake and check the unit is back in IDLE.
    task automatic drain(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({name, "_valid_drop"}, 64'(out_valid), 64'd0);
        check_eq({name, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen_valid;
        logic [WIDTH-1:0] held_res;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_res", 64'(out_res), 64'h00);
`ifdef IMPL_VIOL_CNT_EN
        check_eq("rst_viol", 64'(viol_cnt), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Basic operations, consumer always ready.
        out_ready = 1'b1;
        start_op(8'hF0, 8'h0F);
        wait_result("f0_0f", 8'h0F, 4);
        @(negedge clk);
        check_eq("f0_0f_valid_drop", 64'(out_valid), 64'd0);
        check_eq("f0_0f_ready_back", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        start_op(8'hFF, 8'h00);
        wait_result("ff_00", 8'h00, 8);
        drain("ff_00");

        // Backpressure in DONE with a competing operand pair held on the input.
        start_op(8'h00, 8'h5A);
        wait_result("00_5a", 8'hFF, 0);
        held_res = out_res;
        in_valid = 1'b1;
        in_a     = 8'h3C;
        in_b     = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
        end
        check_eq("bp_res_stable", 64'(out_res), 64'(held_res));
        check_eq("bp_valid_held", 64'(out_valid), 64'd1);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // Handshake edge only returns to IDLE; the held pair is not taken yet.
        check_eq("bp_after_hs_valid", 64'(out_valid), 64'd0);
        check_eq("bp_after_hs_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_pending_accepted", 64'(in_ready), 64'd0);
        wait_result("3c_c3", 8'hC3, 4);
        drain("3c_c3");

        // Reset in the middle of a shift: partial result visible, then discarded.
        start_op(8'h05, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_partial_res", 64'(out_res), 64'h02);
`ifdef IMPL_VIOL_CNT_EN
        check_eq("mid_partial_viol", 64'(viol_cnt), 64'd1);
`endif
        rst = 1'b1;
        #1;
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_out_res", 64'(out_res), 64'h00);
`ifdef IMPL_VIOL_CNT_EN
        check_eq("arst_viol", 64'(viol_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check_eq("no_valid_after_rst", 64'(seen_valid), 64'd0);
        $display("txn reset_mid_shift: valid_pulses=%0d", seen_valid);

        start_op(8'hAA, 8'h55);
        wait_result("aa_55", 8'h55, 4);
        drain("aa_55");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
